// File: rtl/complex_square_accumulator_if.sv
// Sample/result handshake bundle between the squaring stage, the accumulator and its consumer.
interface complex_square_accumulator_if #(
  parameter int WIDTH = 16
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] inReal;
  logic signed [WIDTH-1:0] inImag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] outReal;
  logic signed [WIDTH-1:0] outImag;

  modport slave (
    input  in_valid, inReal, inImag, out_ready,
    output in_ready, out_valid, outReal, outImag
  );

  modport master (
    output in_valid, inReal, inImag, out_ready,
    input  in_ready, out_valid, outReal, outImag
  );
endinterface

// File: rtl/complex_square_accumulator.sv
// Sums LENGTH squared complex samples per frame and presents the narrowed result.
// Define COMPLEX_ACC_SAT_EN to saturate (instead of wrap) when narrowing to WIDTH.
module complex_square_accumulator #(
  parameter  int WIDTH  = 16,
  parameter  int LENGTH = 8,
  localparam int CNT_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1,
  localparam int ACC_W  = WIDTH + CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  complex_square_accumulator_if.slave   bus,
  output logic [CNT_W-1:0]              cnt
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t            stateReg, stateNext;
  logic [CNT_W-1:0]  cntReg, cntNext;
  logic              accept;
  logic              lastSample;
  logic              firstSample;

  assign accept      = bus.in_valid & (stateReg == ACCUM);
  assign lastSample  = (cntReg == CNT_W'(LENGTH - 1));
  assign firstSample = (cntReg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= ACCUM;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (stateReg)
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          if (lastSample) begin
            cntNext   = '0;
            stateNext = DONE;
          end else begin
            cntNext = cntReg + 1'b1;
          end
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) stateNext = ACCUM;
      end
      default: stateNext = ACCUM;
    endcase
  end

  assign cnt = cntReg;

  // Lane 0 carries the real component, lane 1 the imaginary component.
  logic signed [WIDTH-1:0] sample [2];
  assign sample[0] = bus.inReal;
  assign sample[1] = bus.inImag;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : lane
      logic signed [ACC_W-1:0] accReg;
      logic signed [ACC_W-1:0] sampleExt;
      logic signed [ACC_W-1:0] sumNext;
      logic signed [WIDTH-1:0] narrowNext;
      logic signed [WIDTH-1:0] outReg;

      assign sampleExt = {{CNT_W{sample[gi][WIDTH-1]}}, sample[gi]};
      // First sample of a frame overwrites, so no clear cycle is needed.
      assign sumNext   = firstSample ? sampleExt : accReg + sampleExt;

`ifdef COMPLEX_ACC_SAT_EN
      localparam logic signed [ACC_W-1:0] MAX_POS = ACC_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
      localparam logic signed [ACC_W-1:0] MIN_NEG = -MAX_POS - ACC_W'(1);
      always_comb begin
        narrowNext = sumNext[WIDTH-1:0];
        if (sumNext > MAX_POS)      narrowNext = {1'b0, {(WIDTH-1){1'b1}}};
        else if (sumNext < MIN_NEG) narrowNext = {1'b1, {(WIDTH-1){1'b0}}};
      end
`else
      assign narrowNext = sumNext[WIDTH-1:0];
`endif

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          accReg <= '0;
          outReg <= '0;
        end else if (accept) begin
          accReg <= sumNext;
          if (lastSample) outReg <= narrowNext;
        end
      end
    end
  endgenerate

  assign bus.outReal = lane[0].outReg;
  assign bus.outImag = lane[1].outReg;

endmodule

// File: tb/tb_complex_square_accumulator.sv
// Directed bench: LENGTH=4 instance for frame/overflow/backpressure/reset cases, LENGTH=1 instance alongside.
module tb_complex_square_accumulator;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  complex_square_accumulator_if #(.WIDTH(WIDTH)) bus4 ();
  complex_square_accumulator_if #(.WIDTH(WIDTH)) bus1 ();
  logic [1:0] cnt4;
  logic [0:0] cnt1;

  complex_square_accumulator #(.WIDTH(WIDTH), .LENGTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave),
    .cnt (cnt4)
  );

  complex_square_accumulator #(.WIDTH(WIDTH), .LENGTH(1)) dutLen1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave),
    .cnt (cnt1)
  );

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendSample(input logic [15:0] r, input logic [15:0] i);
    bus4.in_valid = 1'b1;
    bus4.inReal   = r;
    bus4.inImag   = i;
    tick();
    bus4.in_valid = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [15:0] expR, input logic [15:0] expI);
    $display("frame %s: out=(%h,%h) valid=%0b", tag, bus4.outReal, bus4.outImag, bus4.out_valid);
    checkValue({tag, " valid"}, 16'(bus4.out_valid), 16'd1);
    checkValue({tag, " in_ready"}, 16'(bus4.in_ready), 16'd0);
    checkValue({tag, " real"}, bus4.outReal, expR);
    checkValue({tag, " imag"}, bus4.outImag, expI);
    checkValue({tag, " cnt"}, 16'(cnt4), 16'd0);
  endtask

  task automatic releaseResult(input string tag);
    bus4.out_ready = 1'b1;
    tick();
    bus4.out_ready = 1'b0;
    checkValue({tag, " release valid"}, 16'(bus4.out_valid), 16'd0);
    checkValue({tag, " release in_ready"}, 16'(bus4.in_ready), 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    bus4.in_valid = 1'b0; bus4.inReal = '0; bus4.inImag = '0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.inReal = '0; bus1.inImag = '0; bus1.out_ready = 1'b0;
    #12;
    checkValue("reset out_valid", 16'(bus4.out_valid), 16'd0);
    checkValue("reset outReal", bus4.outReal, 16'd0);
    checkValue("reset outImag", bus4.outImag, 16'd0);
    checkValue("reset cnt", 16'(cnt4), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkValue("post reset in_ready", 16'(bus4.in_ready), 16'd1);

    // Basic frame: (1,2)+(3,-4)+(5,6)+(-7,8) = (2,12)
    sendSample(16'd1, 16'd2);
    sendSample(16'd3, -16'sd4);
    checkValue("basic cnt after 2", 16'(cnt4), 16'd2);
    sendSample(16'd5, 16'd6);
    checkValue("basic valid before last", 16'(bus4.out_valid), 16'd0);
    sendSample(-16'sd7, 16'd8);
    checkResult("basic", 16'd2, 16'd12);
    releaseResult("basic");

    // Positive overflow: 4 * 0x7FFF = 0x1FFFC
    for (int k = 0; k < 4; k++) sendSample(16'h7FFF, 16'h0001);
`ifdef COMPLEX_ACC_SAT_EN
    checkResult("pos overflow", 16'h7FFF, 16'd4);
`else
    checkResult("pos overflow", 16'hFFFC, 16'd4);
`endif
    releaseResult("pos overflow");

    // Negative overflow: 4 * -32768 = -131072
    for (int k = 0; k < 4; k++) sendSample(16'h8000, 16'hFFFF);
`ifdef COMPLEX_ACC_SAT_EN
    checkResult("neg overflow", 16'h8000, 16'hFFFC);
`else
    checkResult("neg overflow", 16'h0000, 16'hFFFC);
`endif

    // Backpressure: pulsed (9,9) samples in DONE must be ignored
    for (int k = 0; k < 5; k++) begin
      bus4.in_valid = (k % 2 == 0);
      bus4.inReal   = 16'd9;
      bus4.inImag   = 16'd9;
      tick();
      checkValue("bp valid", 16'(bus4.out_valid), 16'd1);
      checkValue("bp cnt", 16'(cnt4), 16'd0);
`ifdef COMPLEX_ACC_SAT_EN
      checkValue("bp real", bus4.outReal, 16'h8000);
`else
      checkValue("bp real", bus4.outReal, 16'h0000);
`endif
      checkValue("bp imag", bus4.outImag, 16'hFFFC);
    end
    bus4.in_valid = 1'b1;
    releaseResult("bp");
    bus4.in_valid = 1'b0;
    checkValue("bp cnt after release", 16'(cnt4), 16'd0);
    for (int k = 0; k < 4; k++) sendSample(16'd1, 16'd1);
    checkResult("after bp", 16'd4, 16'd4);
    releaseResult("after bp");

    // Bubbles then asynchronous reset mid-frame
    sendSample(16'd5, 16'd5);
    tick();
    sendSample(16'd5, 16'd5);
    tick();
    checkValue("bubble cnt", 16'(cnt4), 16'd2);
    #3 rst = 1'b0;
    #1;
    checkValue("midreset cnt", 16'(cnt4), 16'd0);
    checkValue("midreset valid", 16'(bus4.out_valid), 16'd0);
    checkValue("midreset real", bus4.outReal, 16'd0);
    checkValue("midreset imag", bus4.outImag, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      sendSample(16'd1, 16'd1);
      if (k < 3) tick();
    end
    checkResult("after midreset", 16'd4, 16'd4);
    releaseResult("after midreset");

    // Reset while holding a result
    for (int k = 0; k < 4; k++) sendSample(16'd2, 16'd3);
    checkResult("pre done-reset", 16'd8, 16'd12);
    #2 rst = 1'b0;
    #1;
    checkValue("done-reset valid", 16'(bus4.out_valid), 16'd0);
    checkValue("done-reset real", bus4.outReal, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkValue("done-reset in_ready", 16'(bus4.in_ready), 16'd1);

    // LENGTH=1 instance: every sample is a frame
    bus1.in_valid = 1'b1; bus1.inReal = -16'sd3; bus1.inImag = 16'd7;
    tick();
    bus1.in_valid = 1'b0;
    $display("len1 frame: out=(%h,%h) valid=%0b", bus1.outReal, bus1.outImag, bus1.out_valid);
    checkValue("len1 valid", 16'(bus1.out_valid), 16'd1);
    checkValue("len1 real", bus1.outReal, 16'hFFFD);
    checkValue("len1 imag", bus1.outImag, 16'd7);
    checkValue("len1 cnt", 16'(cnt1), 16'd0);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    checkValue("len1 release valid", 16'(bus1.out_valid), 16'd0);
    bus1.in_valid = 1'b1; bus1.inReal = 16'd5; bus1.inImag = -16'sd2;
    tick();
    bus1.in_valid = 1'b0;
    $display("len1 frame: out=(%h,%h) valid=%0b", bus1.outReal, bus1.outImag, bus1.out_valid);
    checkValue("len1 second valid", 16'(bus1.out_valid), 16'd1);
    checkValue("len1 second real", bus1.outReal, 16'd5);
    checkValue("len1 second imag", bus1.outImag, 16'hFFFE);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
